// File: rtl/register_file.sv
// Multi-ported register file: three combinational read ports, two synchronous write ports.
// Port 2 has priority when both ports write the same register in one cycle.
module register_file #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd1,
    input  logic [ADDR_WIDTH-1:0] rd2,
    input  logic [ADDR_WIDTH-1:0] rd3,
    input  logic [ADDR_WIDTH-1:0] wr1,
    input  logic [ADDR_WIDTH-1:0] wr2,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    input  logic [DATA_WIDTH-1:0] wr2_data,
    input  logic                  wr1_enable,
    input  logic                  wr2_enable,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic [DATA_WIDTH-1:0] rd2_data,
    output logic [DATA_WIDTH-1:0] rd3_data
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];

    // Port 2 is applied last so it overrides port 1 on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr1_enable) begin
            regs_d[wr1] = wr1_data;
        end
        if (wr2_enable) begin
            regs_d[wr2] = wr2_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-through bypass: reads see the stored value only.
    assign rd1_data = regs_q[rd1];
    assign rd2_data = regs_q[rd2];
    assign rd3_data = regs_q[rd3];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against a simple array model of the register contents.
module tb_register_file;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 2;
    localparam int unsigned NR = 4;

    logic          clock;
    logic          reset;
    logic [AW-1:0] rd1, rd2, rd3, wr1, wr2;
    logic [DW-1:0] wr1_data, wr2_data;
    logic          wr1_enable, wr2_enable;
    logic [DW-1:0] rd1_data, rd2_data, rd3_data;

    int checks;
    int errors;
    logic [DW-1:0] model [NR];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd1        (rd1),
        .rd2        (rd2),
        .rd3        (rd3),
        .wr1        (wr1),
        .wr2        (wr2),
        .wr1_data   (wr1_data),
        .wr2_data   (wr2_data),
        .wr1_enable (wr1_enable),
        .wr2_enable (wr2_enable),
        .rd1_data   (rd1_data),
        .rd2_data   (rd2_data),
        .rd3_data   (rd3_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge, apply the write rules to the model, settle 1 ns past the edge.
    task automatic step();
        @(posedge clock);
        if (!reset) begin
            if (wr1_enable) model[wr1] = wr1_data;
            if (wr2_enable) model[wr2] = wr2_data;
        end
        #1;
    endtask

    // Point all three read ports at rotations of register r and let outputs settle.
    task automatic peek(input int r, output logic [DW-1:0] v1, output logic [DW-1:0] v2,
                        output logic [DW-1:0] v3);
        rd1 = AW'(r);
        rd2 = AW'((r + 1) % NR);
        rd3 = AW'((r + 2) % NR);
        #1;
        v1 = rd1_data;
        v2 = rd2_data;
        v3 = rd3_data;
    endtask

    task automatic randomize_writes();
        wr1        = AW'($urandom_range(NR - 1));
        wr2        = AW'($urandom_range(NR - 1));
        wr1_data   = DW'($urandom);
        wr2_data   = DW'($urandom);
        wr1_enable = 1'($urandom_range(1));
        wr2_enable = 1'($urandom_range(1));
    endtask

    task automatic test_reset();
        logic [DW-1:0] v1, v2, v3;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        for (int c = 0; c < 4; c++) begin
            randomize_writes();
            step();
            for (int r = 0; r < NR; r++) begin
                peek(r, v1, v2, v3);
                checks++;
                if (v1 !== 16'h0000 || v2 !== 16'h0000 || v3 !== 16'h0000) begin
                    errors++;
                    $display("FAIL reset_hold reg%0d: got %h/%h/%h expected 0000", r, v1, v2, v3);
                end
            end
        end
        @(negedge clock);
        wr1_enable = 1'b0;
        wr2_enable = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_dual_write();
        wr1 = 2'd1; wr1_data = 16'h0010; wr1_enable = 1'b1;
        wr2 = 2'd3; wr2_data = 16'h0020; wr2_enable = 1'b1;
        step();
        wr1_enable = 1'b0;
        wr2_enable = 1'b0;
        rd1 = 2'd1; rd2 = 2'd3; rd3 = 2'd0;
        #1;
        checks++;
        if (rd1_data !== 16'h0010 || rd2_data !== 16'h0020 || rd3_data !== 16'h0000) begin
            errors++;
            $display("FAIL dual_write: got %h/%h/%h expected 0010/0020/0000",
                     rd1_data, rd2_data, rd3_data);
        end
    endtask

    task automatic test_single_write();
        wr1 = 2'd2; wr1_data = 16'hABCD; wr1_enable = 1'b1;
        step();
        wr1_enable = 1'b0;
        rd1 = 2'd2; rd3 = 2'd2; rd2 = 2'd1;
        #1;
        checks++;
        if (rd1_data !== 16'hABCD || rd3_data !== 16'hABCD) begin
            errors++;
            $display("FAIL single_write: got %h/%h expected abcd/abcd", rd1_data, rd3_data);
        end
        checks++;
        if (rd2_data !== 16'h0010) begin
            errors++;
            $display("FAIL keep_reg1: got %h expected 0010", rd2_data);
        end
        rd2 = 2'd3;
        #1;
        checks++;
        if (rd2_data !== 16'h0020) begin
            errors++;
            $display("FAIL keep_reg3: got %h expected 0020", rd2_data);
        end
    endtask

    task automatic test_conflict();
        wr1 = 2'd0; wr1_data = 16'h1111; wr1_enable = 1'b1;
        wr2 = 2'd0; wr2_data = 16'h2222; wr2_enable = 1'b1;
        step();
        wr1_enable = 1'b0;
        wr2_enable = 1'b0;
        rd1 = 2'd0;
        #1;
        checks++;
        if (rd1_data !== 16'h2222) begin
            errors++;
            $display("FAIL conflict: got %h expected 2222", rd1_data);
        end
    endtask

    task automatic test_no_bypass();
        rd1 = 2'd1;
        wr1 = 2'd1; wr1_data = 16'h5555; wr1_enable = 1'b1;
        #1;
        checks++;
        if (rd1_data !== 16'h0010) begin
            errors++;
            $display("FAIL no_bypass_before: got %h expected 0010", rd1_data);
        end
        step();
        checks++;
        if (rd1_data !== 16'h5555) begin
            errors++;
            $display("FAIL no_bypass_after: got %h expected 5555", rd1_data);
        end
        wr1_enable = 1'b0;
        wr1_data   = 16'hFFFF;
        step();
        checks++;
        if (rd1_data !== 16'h5555) begin
            errors++;
            $display("FAIL disabled_write: got %h expected 5555", rd1_data);
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] v1, v2, v3;
        wr1 = 2'd1; wr1_data = 16'h7777; wr1_enable = 1'b1;
        wr2 = 2'd2; wr2_data = 16'h8888; wr2_enable = 1'b1;
        rd1 = 2'd0; rd2 = 2'd1; rd3 = 2'd2;
        #2;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        checks++;
        if (rd1_data !== 16'h0000 || rd2_data !== 16'h0000 || rd3_data !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h/%h/%h expected 0000",
                     rd1_data, rd2_data, rd3_data);
        end
        step();
        @(negedge clock);
        reset      = 1'b0;
        wr1_enable = 1'b0;
        wr2_enable = 1'b0;
        step();
        step();
        for (int r = 0; r < NR; r++) begin
            peek(r, v1, v2, v3);
            checks++;
            if (v1 !== 16'h0000 || v2 !== 16'h0000 || v3 !== 16'h0000) begin
                errors++;
                $display("FAIL async_reset_after reg%0d: got %h/%h/%h expected 0000",
                         r, v1, v2, v3);
            end
        end
        wr2 = 2'd3; wr2_data = 16'h3C3C; wr2_enable = 1'b1;
        step();
        wr2_enable = 1'b0;
        rd3 = 2'd3;
        #1;
        checks++;
        if (rd3_data !== 16'h3C3C) begin
            errors++;
            $display("FAIL write_after_reset: got %h expected 3c3c", rd3_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            randomize_writes();
            rd1 = AW'($urandom_range(NR - 1));
            rd2 = AW'($urandom_range(NR - 1));
            rd3 = AW'($urandom_range(NR - 1));
            #1;
            checks++;
            if (rd1_data !== model[rd1] || rd2_data !== model[rd2] || rd3_data !== model[rd3]) begin
                errors++;
                $display("FAIL random_pre iter%0d: got %h/%h/%h expected %h/%h/%h", n,
                         rd1_data, rd2_data, rd3_data, model[rd1], model[rd2], model[rd3]);
            end
            step();
            rd1 = AW'($urandom_range(NR - 1));
            rd2 = AW'($urandom_range(NR - 1));
            rd3 = AW'($urandom_range(NR - 1));
            #1;
            checks++;
            if (rd1_data !== model[rd1] || rd2_data !== model[rd2] || rd3_data !== model[rd3]) begin
                errors++;
                $display("FAIL random_post iter%0d: got %h/%h/%h expected %h/%h/%h", n,
                         rd1_data, rd2_data, rd3_data, model[rd1], model[rd2], model[rd3]);
            end
        end
        wr1_enable = 1'b0;
        wr2_enable = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        rd1        = '0;
        rd2        = '0;
        rd3        = '0;
        wr1        = '0;
        wr2        = '0;
        wr1_data   = '0;
        wr2_data   = '0;
        wr1_enable = 1'b0;
        wr2_enable = 1'b0;
        test_reset();
        @(negedge clock);
        test_dual_write();
        test_single_write();
        test_conflict();
        test_no_bypass();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
